// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//
// Memory-mapped 32-bit countdown timer with interrupt request. Two instances
// sit behind the system bridge (Timer0 at 0x7F00, Timer1 at 0x7F10); the
// bridge has already qualified WE for this instance, so only Addr[3:2] is
// decoded here.
//
// Register map (Addr[3:2]):
//   0 CTRL   : [0] Enable, [2:1] Mode, [3] IM (interrupt mask), [31:4] read 0
//   1 PRESET : 32-bit reload value, read/write
//   2 COUNT  : current count, read-only
//   3 -      : reads 0, writes ignored
//
// Modes: 1 = auto-reload with a one-cycle IRQ pulse per period;
//        0/2/3 = one-shot, Enable self-clears and the IRQ holds until a
//        CTRL or PRESET write.
//
// Optional build macro TIMER_PRESCALER_EN: COUNT decrements once every
// PRESCALE cycles in CNT instead of every cycle.
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   Addr      device address (only [3:2] decoded)
//   WE        write enable for this instance
//   Din       write data
//   Dout      read data, combinational from Addr[3:2]
//   IRQ       registered interrupt request (IM & irq_flag)
//   dbg_state FSM state for observation (0 IDLE, 1 LOAD, 2 CNT, 3 INT)
//
// Bus handshake: there is no valid/ready pair; a write is a single-cycle
// transfer accepted on every rising edge where WE=1, and a read is a pure
// combinational decode of Addr with zero latency and no side effects.
// -----------------------------------------------------------------------------
module timer_counter #(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] MODE_AUTO  = 2'd1;

  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  logic        tick;

  logic        addr_unused;
  assign addr_unused = ^{Addr[31:4], Addr[1:0]};

  assign dbg_state = state;

`ifdef TIMER_PRESCALER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_cnt;

  // The decrement/expiry check fires on the last cycle of each prescale window.
  assign tick = (pre_cnt == PW'(PRESCALE - 1));

  // Runs only while actively counting; any other state restarts the window
  // so every LOAD begins a full PRESCALE-cycle window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= '0;
    end else if (state == ST_CNT && ctrl[0]) begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
    end else begin
      pre_cnt <= '0;
    end
  end
`else
  logic cfg_unused;
  assign cfg_unused = (PRESCALE < 1);
  assign tick = 1'b1;
`endif

  // FSM, registers and IRQ in one block. The bus write is placed after the
  // FSM so that, for the same edge, a CTRL/PRESET write overrides both the
  // Enable clear and the irq_flag set performed by INT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
      IRQ      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl[0]) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl[0]) begin
            state <= ST_IDLE;
          end else if (tick) begin
            // Expire at 1 (or at 0 for PRESET=0) so COUNT never wraps.
            if (count > 32'd1) begin
              count <= count - 32'd1;
            end else begin
              count <= '0;
              state <= ST_INT;
            end
          end
        end
        ST_INT: begin
          irq_flag <= 1'b1;
          state    <= ST_IDLE;
          if (ctrl[2:1] != MODE_AUTO) ctrl[0] <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

      // Auto-reload mode: the flag lives for exactly one cycle after INT.
      if (ctrl[2:1] == MODE_AUTO && irq_flag && state != ST_INT) irq_flag <= 1'b0;

      if (WE) begin
        case (Addr[3:2])
          REG_CTRL: begin
            ctrl     <= Din[3:0];
            irq_flag <= 1'b0;
          end
          REG_PRESET: begin
            preset   <= Din;
            irq_flag <= 1'b0;
          end
          default: ;
        endcase
      end

      IRQ <= ctrl[3] & irq_flag;
    end
  end

  always_comb begin
    Dout = '0;
    case (Addr[3:2])
      REG_CTRL:   Dout = {28'd0, ctrl};
      REG_PRESET: Dout = preset;
      REG_COUNT:  Dout = count;
      default:    Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// -----------------------------------------------------------------------------
// tb_timer_counter
//
// Self-checking bench for timer_counter. Expected COUNT, CTRL and IRQ values
// come from closed-form timing of the countdown: with the CTRL write landing
// on edge W, COUNT is loaded on edge W+2, decrements once per PS cycles, the
// expiry (INT) state is entered on edge W+2+max(P,1)*PS, and IRQ follows two
// edges later. Auto-reload repeats every P*PS+3 edges.
// -----------------------------------------------------------------------------
module tb_timer_counter;

`ifdef TIMER_PRESCALER_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [27:0] base_hi = 28'h00007F0;
  logic [31:0] exp_q[$];

  timer_counter #(.PRESCALE(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .Addr     (Addr),
    .WE       (WE),
    .Din      (Din),
    .Dout     (Dout),
    .IRQ      (IRQ),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model helpers ----------------
  function automatic logic [31:0] exp_count(input int p, input int j);
    int d;
    d = (j - 1) / PS;
    return (d >= p) ? 32'd0 : 32'(p - d);
  endfunction

  function automatic int int_edge(input int w, input int p);
    return w + 2 + ((p < 1) ? 1 : p) * PS;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] r, input logic [31:0] d);
    Addr = {base_hi, r, 2'($urandom_range(0, 3))};
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE   = 1'b0;
    Din  = $urandom;
  endtask

  task automatic bus_read(input logic [1:0] r, output logic [31:0] d);
    Addr = {base_hi, r, 2'($urandom_range(0, 3))};
    #1;
    d = Dout;
  endtask

  function automatic logic [1:0] oneshot_mode();
    logic [1:0] m;
    m = 2'($urandom_range(0, 2));
    return (m == 2'd1) ? 2'd3 : m;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    WE = 1'b0;
    Addr = '0;
    Din = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int r = 0; r < 4; r++) begin
      bus_read(2'(r), d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %0h expected 0", r, d);
      end
    end
    checks++;
    if (IRQ !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b expected 0", IRQ);
    end
    reset_n = 1'b1;
    tick_edge();
  endtask

  task automatic test_regs();
    logic [3:0]  ctrl_m;
    logic [31:0] preset_m, d, wd;
    logic [1:0]  r;
    ctrl_m = '0;
    preset_m = '0;
    for (int i = 0; i < 8; i++) begin
      base_hi = $urandom_range(0, 1) ? 28'h00007F1 : 28'h00007F0;
      r = 2'($urandom_range(0, 3));
      wd = $urandom;
      if (r == 2'd0) wd[0] = 1'b0;  // keep the timer idle
      bus_write(r, wd);
      if (r == 2'd0) ctrl_m = wd[3:0];
      if (r == 2'd1) preset_m = wd;
      bus_read(2'd0, d);
      checks++;
      if (d !== {28'd0, ctrl_m}) begin
        errors++;
        $display("FAIL regs_ctrl: got %0h expected %0h", d, {28'd0, ctrl_m});
      end
      bus_read(2'd1, d);
      checks++;
      if (d !== preset_m) begin
        errors++;
        $display("FAIL regs_preset: got %0h expected %0h", d, preset_m);
      end
      bus_read(2'd2, d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL regs_count: got %0h expected 0", d);
      end
      bus_read(2'd3, d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL regs_unmapped: got %0h expected 0", d);
      end
    end
    bus_write(2'd0, 32'd0);
  endtask

  task automatic test_oneshot(input int p, input logic im, input logic [1:0] mode);
    int w, x, n, j;
    logic [31:0] c, d, ec;
    c = {28'd0, im, mode, 1'b1};
    bus_write(2'd1, 32'(p));
    bus_write(2'd0, c);
    w = cyc;
    x = int_edge(w, p);
    while (cyc < x + 4) begin
      tick_edge();
      n = cyc;
      j = n - w - 1;
      if (j >= 1) begin
        bus_read(2'd2, d);
        checks++;
        if (d !== exp_count(p, j)) begin
          errors++;
          $display("FAIL oneshot_count p=%0d j=%0d: got %0d expected %0d", p, j, d, exp_count(p, j));
        end
      end
      ec = (n >= x + 1) ? (c & 32'hE) : c;
      bus_read(2'd0, d);
      checks++;
      if (d !== ec) begin
        errors++;
        $display("FAIL oneshot_ctrl p=%0d edge=%0d: got %0h expected %0h", p, n - w, d, ec);
      end
      checks++;
      if (IRQ !== (im && n >= x + 2)) begin
        errors++;
        $display("FAIL oneshot_irq p=%0d edge=%0d: got %b expected %b", p, n - w, IRQ, im && n >= x + 2);
      end
    end
    // IRQ holds through the clearing edge, then drops.
    bus_write(2'd1, 32'($urandom_range(0, 50)));
    checks++;
    if (IRQ !== im) begin
      errors++;
      $display("FAIL oneshot_hold: got %b expected %b", IRQ, im);
    end
    tick_edge();
    checks++;
    if (IRQ !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_clear: got %b expected 0", IRQ);
    end
  endtask

  task automatic test_periodic(input int p);
    int w, t, first, last, n;
    logic expect_hi;
    bus_write(2'd1, 32'(p));
    bus_write(2'd0, 32'hB);
    w = cyc;
    t = p * PS + 3;
    first = int_edge(w, p) + 2;
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back(32'(first + k * t));
    last = first + 3 * t + 1;
    while (cyc < last) begin
      tick_edge();
      n = cyc;
      expect_hi = (exp_q.size() > 0 && exp_q[0] == 32'(n));
      if (expect_hi) void'(exp_q.pop_front());
      checks++;
      if (IRQ !== expect_hi) begin
        errors++;
        $display("FAIL periodic_irq p=%0d edge=%0d: got %b expected %b", p, n - w, IRQ, expect_hi);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL periodic_pulses p=%0d: got %0d missing expected 0", p, exp_q.size());
    end
    bus_write(2'd0, 32'd0);
    repeat (3) tick_edge();
  endtask

  // A CTRL write landing on the INT edge keeps Enable and suppresses the flag.
  task automatic test_collision(input int p);
    int w, x;
    logic [31:0] d;
    bus_write(2'd1, 32'(p));
    bus_write(2'd0, 32'h9);
    w = cyc;
    x = int_edge(w, p);
    repeat (x - w) tick_edge();
    bus_write(2'd0, 32'h9);
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'h9) begin
      errors++;
      $display("FAIL collision_ctrl: got %0h expected 9", d);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (IRQ !== 1'b0) begin
        errors++;
        $display("FAIL collision_irq k=%0d: got %b expected 0", k, IRQ);
      end
      if (k < 2) tick_edge();
    end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'(p)) begin
      errors++;
      $display("FAIL collision_reload: got %0d expected %0d", d, p);
    end
    bus_write(2'd0, 32'd0);
    repeat (3) tick_edge();
  endtask

  task automatic test_disable(input int p, input int q);
    int w, j, j3;
    logic [31:0] d, frozen;
    bus_write(2'd1, 32'(p));
    bus_write(2'd0, 32'h9);
    w = cyc;
    tick_edge();
    // PRESET changes after LOAD must not disturb the running count.
    bus_write(2'd1, 32'(q));
    j3 = (p - 3) * PS + 1;
    j = cyc - w - 1;
    while (j < j3) begin
      tick_edge();
      j = cyc - w - 1;
      bus_read(2'd2, d);
      checks++;
      if (d !== exp_count(p, j)) begin
        errors++;
        $display("FAIL disable_count j=%0d: got %0d expected %0d", j, d, exp_count(p, j));
      end
    end
    bus_write(2'd0, 32'd0);
    frozen = exp_count(p, j3 + 1);
    for (int k = 0; k < 8; k++) begin
      tick_edge();
      bus_read(2'd2, d);
      checks++;
      if (d !== frozen) begin
        errors++;
        $display("FAIL disable_freeze k=%0d: got %0d expected %0d", k, d, frozen);
      end
      checks++;
      if (IRQ !== 1'b0) begin
        errors++;
        $display("FAIL disable_irq k=%0d: got %b expected 0", k, IRQ);
      end
    end
    bus_write(2'd0, 32'h9);
    repeat (2) tick_edge();
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'(q)) begin
      errors++;
      $display("FAIL disable_reload: got %0d expected %0d", d, q);
    end
    bus_write(2'd0, 32'd0);
    repeat (3) tick_edge();
  endtask

  task automatic test_masked(input int p, input logic [1:0] mode);
    int w, x;
    logic [31:0] d;
    bus_write(2'd1, 32'(p));
    bus_write(2'd0, {28'd0, 1'b0, mode, 1'b1});
    w = cyc;
    x = int_edge(w, p);
    while (cyc < x + 4) begin
      tick_edge();
      checks++;
      if (IRQ !== 1'b0) begin
        errors++;
        $display("FAIL masked_irq edge=%0d: got %b expected 0", cyc - w, IRQ);
      end
    end
    bus_read(2'd0, d);
    checks++;
    if (d !== {29'd0, mode, 1'b0}) begin
      errors++;
      $display("FAIL masked_ctrl: got %0h expected %0h", d, {29'd0, mode, 1'b0});
    end
    bus_write(2'd0, 32'h8);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (IRQ !== 1'b0) begin
        errors++;
        $display("FAIL masked_unmask k=%0d: got %b expected 0", k, IRQ);
      end
      tick_edge();
    end
    for (int b = 0; b < 2; b++) begin
      base_hi = (b == 0) ? 28'h00007F0 : 28'h00007F1;
      bus_read(2'd3, d);
      checks++;
      if (d !== 32'd0) begin
        errors++;
        $display("FAIL masked_unmapped base=%0h: got %0h expected 0", base_hi, d);
      end
    end
    bus_write(2'd0, 32'd0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus_write(2'd1, 32'd7);
    bus_write(2'd0, 32'h9);
    repeat (2) tick_edge();
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'd7) begin
      errors++;
      $display("FAIL rstmid_pre: got %0d expected 7", d);
    end
    #1;
    reset_n = 1'b0;
    #1;
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_count: got %0d expected 0", d);
    end
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_ctrl: got %0h expected 0", d);
    end
    checks++;
    if (IRQ !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_irq: got %b expected 0", IRQ);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) tick_edge();
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_idle: got %0d expected 0", d);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_regs();
    base_hi = 28'h00007F0;
    test_oneshot(5, 1'b1, 2'd0);
    test_oneshot(0, 1'b1, oneshot_mode());
    for (int i = 0; i < 3; i++) begin
      base_hi = $urandom_range(0, 1) ? 28'h00007F1 : 28'h00007F0;
      test_oneshot($urandom_range(1, 9), 1'($urandom_range(0, 1)), oneshot_mode());
    end
    test_periodic(5);
    test_periodic(2);
    test_periodic($urandom_range(1, 8));
    test_collision($urandom_range(1, 6));
    test_disable($urandom_range(6, 15), $urandom_range(20, 40));
    test_disable($urandom_range(6, 15), $urandom_range(20, 40));
    test_masked($urandom_range(0, 6), oneshot_mode());
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
